// File: rtl/ma_sample_sequencer.sv
// ma_sample_sequencer: sample-strobe sequencer in front of the moving-average filter core.
// Define MA_SEQ_SYNC_EN to pass strobe_in through a 2-flop synchronizer ahead of the edge detector.
module ma_sample_sequencer #(
    parameter int unsigned DW      = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          strobe_in,
    input  logic [DW-1:0] sample_in,
    input  logic [1:0]    sel_req,
    input  logic          err_clr,
    output logic [DW-1:0] filt_data,
    output logic          filt_strobe,
    output logic [1:0]    filt_select,
    output logic          filt_clear,
    input  logic [DW-1:0] filt_result,
    input  logic          filt_done,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          warming,
    output logic          overrun,
    output logic          timeout_err
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECONF = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          pend_vld_q, pend_vld_d;
    logic [DW-1:0] pend_data_q, pend_data_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] warm_q, warm_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic          clr_q, clr_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;
    logic          warming_q, warming_d;
    logic          strb_q;
    logic          strb_s;
    logic          stb_edge;
    logic          dispatch_c;

    function automatic logic [CW-1:0] win_len(input logic [1:0] sel);
        return CW'(5'd2 << sel);
    endfunction

`ifdef MA_SEQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], strobe_in};
    end

    assign strb_s = sync_q[1];
`else
    assign strb_s = strobe_in;
`endif

    assign stb_edge = strb_s & ~strb_q & ena;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        sel_d       = sel_q;
        warm_d      = warm_q;
        timer_d     = timer_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        ovr_d       = ovr_q;
        tmo_d       = tmo_q;
        clr_d       = 1'b0;
        stb_d       = 1'b0;
        dispatch_c  = 1'b0;

        if (err_clr) begin
            ovr_d = 1'b0;
            tmo_d = 1'b0;
        end

        // Intake: IDLE drains pending first and parks a same-cycle edge behind it
        if (state_q == S_IDLE) begin
            if (pend_vld_q) begin
                hold_d     = pend_data_q;
                dispatch_c = 1'b1;
                pend_vld_d = stb_edge;
                if (stb_edge) pend_data_d = sample_in;
            end else if (stb_edge) begin
                hold_d     = sample_in;
                dispatch_c = 1'b1;
            end
        end else if (stb_edge) begin
            if (pend_vld_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_vld_d  = 1'b1;
                pend_data_d = sample_in;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (dispatch_c) begin
                    if (sel_req != sel_q) begin
                        state_d = S_RECONF;
                        clr_d   = 1'b1;
                        sel_d   = sel_req;
                        warm_d  = '0;
                    end else begin
                        state_d = S_ISSUE;
                        stb_d   = 1'b1;
                    end
                end
            end
            S_RECONF: begin
                state_d = S_ISSUE;
                stb_d   = 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                if (filt_done) begin
                    out_data_d  = filt_result;
                    warm_d      = (warm_q >= win_len(sel_q)) ? win_len(sel_q) : warm_q + CW'(1);
                    out_valid_d = (warm_d == win_len(sel_q));
                    state_d     = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE) || pend_vld_d;
        warming_d = (warm_d < win_len(sel_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            sel_q       <= 2'd0;
            warm_q      <= '0;
            timer_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
            clr_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            warming_q   <= 1'b0;
            strb_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            sel_q       <= sel_d;
            warm_q      <= warm_d;
            timer_q     <= timer_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
            tmo_q       <= tmo_d;
            clr_q       <= clr_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            warming_q   <= warming_d;
            strb_q      <= strb_s;
        end
    end

    assign filt_data   = hold_q;
    assign filt_strobe = stb_q;
    assign filt_select = sel_q;
    assign filt_clear  = clr_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign warming     = warming_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ma_sample_sequencer.sv
// tb_ma_sample_sequencer: directed scenarios plus randomized traffic against a transaction-level model.
// Honours MA_SEQ_SYNC_EN the same way the design does.
module tb_ma_sample_sequencer;
    localparam int unsigned DW      = 10;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned VW      = 9 + 2 * DW;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          strobe_in;
    logic [DW-1:0] sample_in;
    logic [1:0]    sel_req;
    logic          err_clr;
    logic [DW-1:0] filt_data;
    logic          filt_strobe;
    logic [1:0]    filt_select;
    logic          filt_clear;
    logic [DW-1:0] filt_result;
    logic          filt_done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          warming;
    logic          overrun;
    logic          timeout_err;

    ma_sample_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .strobe_in(strobe_in), .sample_in(sample_in),
        .sel_req(sel_req), .err_clr(err_clr), .filt_data(filt_data), .filt_strobe(filt_strobe),
        .filt_select(filt_select), .filt_clear(filt_clear), .filt_result(filt_result),
        .filt_done(filt_done), .out_data(out_data), .out_valid(out_valid), .busy(busy),
        .warming(warming), .overrun(overrun), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Filter stand-in: echoes the strobed sample f_lat cycles later; f_lat==0 never answers
    int            f_lat  = 3;
    logic          f_spur = 1'b0;
    int            f_cnt  = 0;
    logic [DW-1:0] f_val  = '0;

    initial begin
        forever begin
            @(negedge clk);
            filt_done = 1'b0;
            if (f_cnt > 0) begin
                f_cnt--;
                if (f_cnt == 0) begin
                    filt_done   = 1'b1;
                    filt_result = f_val;
                end
            end else if (f_spur && $urandom_range(39) == 0) begin
                filt_done   = 1'b1;
                filt_result = DW'($urandom);
            end
            if (filt_strobe && f_lat > 0) begin
                f_cnt = f_lat;
                f_val = filt_data;
            end
        end
    end

    // Transaction-level reference: one sample in flight, a queue of waiting samples
`ifdef MA_SEQ_SYNC_EN
    logic [1:0]    m_sy;
`endif
    logic          m_prev, m_act, m_rc, m_ov, m_ovr, m_tmo, m_fresh;
    int            m_age, m_warm;
    logic [1:0]    m_sel;
    logic [DW-1:0] m_hold, m_od;
    logic [DW-1:0] m_pq[$];

    function automatic int win(input logic [1:0] s);
        return 2 << s;
    endfunction

    task automatic model_reset();
`ifdef MA_SEQ_SYNC_EN
        m_sy = 2'b00;
`endif
        m_prev = 1'b0; m_act = 1'b0; m_rc = 1'b0; m_ov = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
        m_fresh = 1'b1; m_age = 0; m_warm = 0; m_sel = 2'd0; m_hold = '0; m_od = '0;
        m_pq.delete();
    endtask

    task automatic model_step();
        logic s_cur;
        logic e;
        logic go;
        int   iss;
`ifdef MA_SEQ_SYNC_EN
        s_cur = m_sy[1];
        m_sy  = {m_sy[0], strobe_in};
`else
        s_cur = strobe_in;
`endif
        e       = s_cur & ~m_prev & ena;
        m_prev  = s_cur;
        m_ov    = 1'b0;
        m_fresh = 1'b0;
        if (err_clr) begin
            m_ovr = 1'b0;
            m_tmo = 1'b0;
        end
        if (!m_act) begin
            go = 1'b0;
            if (m_pq.size() > 0) begin
                m_hold = m_pq.pop_front();
                go = 1'b1;
                if (e) m_pq.push_back(sample_in);
            end else if (e) begin
                m_hold = sample_in;
                go = 1'b1;
            end
            if (go) begin
                m_act = 1'b1;
                m_age = 1;
                m_rc  = (sel_req != m_sel);
                if (m_rc) begin
                    m_sel  = sel_req;
                    m_warm = 0;
                end
            end
        end else begin
            if (e) begin
                if (m_pq.size() > 0) m_ovr = 1'b1;
                else m_pq.push_back(sample_in);
            end
            iss = m_rc ? 2 : 1;
            if (m_age > iss) begin
                if (filt_done) begin
                    m_od = filt_result;
                    if (m_warm < win(m_sel)) m_warm++;
                    m_ov  = (m_warm == win(m_sel));
                    m_act = 1'b0;
                end else if (m_age - iss - 1 == int'(TIMEOUT) - 1) begin
                    m_tmo = 1'b1;
                    m_act = 1'b0;
                end else begin
                    m_age++;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        int   iss;
        logic stb;
        logic clr;
        logic bsy;
        logic wrm;
        iss = m_rc ? 2 : 1;
        stb = m_act && (m_age == iss);
        clr = m_act && m_rc && (m_age == 1);
        bsy = m_act || (m_pq.size() > 0);
        wrm = m_fresh ? 1'b0 : (m_warm < win(m_sel));
        return {stb, clr, m_sel, m_ov, bsy, wrm, m_ovr, m_tmo, m_od, stb ? m_hold : DW'(0)};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {filt_strobe, filt_clear, filt_select, out_valid, busy, warming, overrun,
                timeout_err, out_data, filt_strobe ? filt_data : DW'(0)};
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({filt_data, filt_strobe, filt_select, filt_clear, out_data, out_valid,
                    busy, warming, overrun, timeout_err});
    endfunction

    initial begin
        logic [VW-1:0] a;
        logic [VW-1:0] x;
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                a = act_vec();
                x = exp_vec();
                n_tests++;
                if (a !== x) begin
                    n_fail++;
                    $display("FAIL cycle_compare t=%0t: dut {stb,clr,sel,ov,busy,warm,ovr,tmo,od,fd}=%h model=%h",
                             $time, a, x);
                end
            end
        end
    end

    int            cyc = 0;
    int            n_stb = 0;
    int            n_clr = 0;
    int            n_val = 0;
    int            stb_cyc = 0;
    logic [DW-1:0] last_od = '0;
    logic          last_warm = 1'b0;
    logic          busy_seen = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (filt_strobe) begin
                n_stb++;
                stb_cyc = cyc;
            end
            if (filt_clear) n_clr++;
            if (out_valid) begin
                n_val++;
                last_od   = out_data;
                last_warm = warming;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic edge_pulse(input logic [DW-1:0] v);
        sample_in = v;
        strobe_in = 1'b1;
        repeat (2) tick();
        strobe_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: busy still 1 after %0d cycles, required 0", nm, k);
        end
        tick();
    endtask

    int b0, c0, v0, k;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; strobe_in = 1'b0; sample_in = '0; sel_req = 2'd1; err_clr = 1'b0;
        filt_done = 1'b0; filt_result = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reconfigure to a 4-sample window, then fill it
        b0 = n_stb; c0 = n_clr; v0 = n_val;
        edge_pulse(DW'(100)); wait_idle("t1_s1");
        edge_pulse(DW'(200)); wait_idle("t1_s2");
        edge_pulse(DW'(300)); wait_idle("t1_s3");
        edge_pulse(DW'(400)); wait_idle("t1_s4");
        check("t1_strobes", n_stb - b0, 4);
        check("t1_clears", n_clr - c0, 1);
        check("t1_valids", n_val - v0, 1);
        check("t1_out_data", last_od, 400);
        check("t1_warming_at_valid", last_warm, 0);

        // Select change mid-WAIT applies on the following sample
        f_lat = 8; v0 = n_val;
        edge_pulse(DW'(7));
        sel_req = 2'd3;
        wait_idle("t2_inflight");
        check("t2_inflight_valid", n_val - v0, 1);
        check("t2_inflight_data", last_od, 7);
        f_lat = 3; c0 = n_clr; v0 = n_val;
        for (int i = 0; i < 16; i++) begin
            edge_pulse(DW'(500 + i));
            if (i == 0) begin
                check("t2_select", filt_select, 3);
                check("t2_warming", warming, 1);
            end
            wait_idle("t2_fill");
        end
        check("t2_clears", n_clr - c0, 1);
        check("t2_valids", n_val - v0, 1);
        check("t2_last_data", last_od, 515);

        // Three quick edges against a slow filter: issue, pend, drop
        f_lat = 10; b0 = n_stb; v0 = n_val;
        for (int i = 0; i < 3; i++) begin
            sample_in = DW'(600 + i);
            strobe_in = 1'b1; tick();
            strobe_in = 1'b0; tick();
        end
        repeat (3) tick();
        wait_idle("t3");
        check("t3_strobes", n_stb - b0, 2);
        check("t3_valids", n_val - v0, 2);
        check("t3_overrun", overrun, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t3_err_clr", overrun, 0);

        // Filter never answers
        f_lat = 0; b0 = n_stb; v0 = n_val;
        edge_pulse(DW'(77));
        k = 0;
        while (!timeout_err && k < 200) begin
            tick();
            k++;
        end
        check("t4_timeout_delay", cyc - stb_cyc, 65);
        check("t4_busy", busy, 0);
        check("t4_no_valid", n_val - v0, 0);
        f_lat = 3;
        tick();
        edge_pulse(DW'(88)); wait_idle("t4_reissue");
        check("t4_reissue", n_stb - b0, 2);
        check("t4_result", last_od, 88);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_err_clr", timeout_err, 0);

        // Disabled edges are ignored entirely
        ena = 1'b0; b0 = n_stb; busy_seen = 1'b0;
        edge_pulse(DW'(1));
        edge_pulse(DW'(2));
        tick();
        check("t5_no_strobe", n_stb - b0, 0);
        check("t5_busy", busy_seen, 0);
        check("t5_overrun", overrun, 0);
        ena = 1'b1;
        edge_pulse(DW'(3)); wait_idle("t5_resume");
        check("t5_resume", n_stb - b0, 1);

        // Reset during WAIT with pending occupied
        f_lat = 20;
        edge_pulse(DW'(11));
        edge_pulse(DW'(12));
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", all_outs(), 32'd0);
        tick();
        rst_n = 1'b1;
        b0 = n_stb; v0 = n_val;
        repeat (40) tick();
        check("t6_no_strobe", n_stb - b0, 0);
        check("t6_no_valid", n_val - v0, 0);
        f_lat = 3;
        edge_pulse(DW'(13)); wait_idle("t6_new_edge");
        check("t6_new_edge", n_stb - b0, 1);

        // Randomized traffic, including spurious done pulses and one mid-run reset
        f_spur = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            ena = ($urandom_range(15) != 0);
            if ($urandom_range(2) == 0) begin
                strobe_in = ~strobe_in;
                if (strobe_in) sample_in = DW'($urandom);
            end
            if ($urandom_range(199) == 0) sel_req = 2'($urandom);
            err_clr = ($urandom_range(39) == 0);
            if ($urandom_range(49) == 0) f_lat = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(12, 1));
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            tick();
        end
        f_spur = 1'b0; strobe_in = 1'b0; err_clr = 1'b0; ena = 1'b1; f_lat = 3;
        repeat (100) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
